sprite_rom_arbiter: RTL and testbench

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_arb_pkg.sv | 17 +
 rtl/sprite_rom_arbiter_rr_pick.sv | 32 +++
 rtl/sprite_rom_arbiter.sv | 146 ++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_arb_pkg.sv
// Shared types and default constants for the sprite ROM arbiter.
// Optional stats counters are enabled with SPRITE_ARB_STATS_EN.
package sprite_arb_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 5;
  localparam int DEF_BURST_MAX = 8;
  localparam int CNT_W         = 8;
  localparam int STAT_W        = 16;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Round-robin search: first set req bit at or above ptr, wrapping.
// Returns the winner one-hot plus its index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        onehot[j] = 1'b1;
        idx       = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter with lockable bursts in front of a sprite ROM.
// Define SPRITE_ARB_STATS_EN to add saturating per-requester grant counters.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rvalid,
`ifdef SPRITE_ARB_STATS_EN
  output logic [N_REQ*STAT_W-1:0] grant_cnt,
`endif
  output logic [DATA_W-1:0]       rdata
);

  localparam int IW = $clog2(N_REQ);

  arb_state_e        state, state_n;
  logic [IW-1:0]     ptr, ptr_n;
  logic [IW-1:0]     owner, owner_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] addr_q;

  logic [IW-1:0]     base;
  logic [N_REQ-1:0]  pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_ok;

  logic [N_REQ-1:0]  gnt_c;
  logic [IW-1:0]     sel;
  logic              grant;
  logic              keep;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // During a burst the search starts just past the owner.
  assign base = (state == BURST) ? nxt(owner) : ptr;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (base),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_ok)
  );

  assign keep = (state == BURST) && req[owner] &&
                (cnt < CNT_W'(BURST_MAX));

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = cnt;
    gnt_c   = '0;
    sel     = '0;
    grant   = 1'b0;
    if (keep) begin
      gnt_c[owner] = 1'b1;
      sel          = owner;
      grant        = 1'b1;
      if (lock[owner]) begin
        cnt_n = cnt + 1'b1;
      end else begin
        state_n = IDLE;
        ptr_n   = nxt(owner);
        cnt_n   = '0;
      end
    end else begin
      state_n = IDLE;
      cnt_n   = '0;
      if (state == BURST) ptr_n = nxt(owner);
      if (pick_ok) begin
        gnt_c = pick_oh;
        sel   = pick_idx;
        grant = 1'b1;
        // A one-grant burst is just a plain grant.
        if (lock[pick_idx] && BURST_MAX > 1) begin
          state_n = BURST;
          owner_n = pick_idx;
          cnt_n   = CNT_W'(1);
        end else begin
          ptr_n = nxt(pick_idx);
        end
      end
    end
  end

  assign gnt      = reset_n ? gnt_c : '0;
  assign rom_addr = (grant && reset_n) ?
                    addr[int'(sel)*ADDR_W +: ADDR_W] : addr_q;
  assign rdata    = rom_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      cnt    <= '0;
      addr_q <= '0;
      rvalid <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      owner  <= owner_n;
      cnt    <= cnt_n;
      rvalid <= gnt;
      if (grant) addr_q <= rom_addr;
    end
  end

`ifdef SPRITE_ARB_STATS_EN
  logic [STAT_W-1:0] stat [N_REQ];

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) stat[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (gnt[i] && stat[i] != '1) stat[i] <= stat[i] + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++)
      grant_cnt[i*STAT_W +: STAT_W] = stat[i];
  end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboarded bench for sprite_rom_arbiter with a mod-32 ROM model.
// Build with SPRITE_ARB_STATS_EN to include the saturation scenario.
module tb_sprite_rom_arbiter;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [39:0] addr;
  logic [3:0]  gnt;
  logic [9:0]  rom_addr;
  logic [4:0]  rom_q;
  logic [3:0]  rvalid;
  logic [4:0]  rdata;
`ifdef SPRITE_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0] a [4];

  typedef struct {
    logic [3:0] v;
    logic [4:0] d;
    int         c;
  } exp_t;

  exp_t sb[$];

  sprite_rom_arbiter dut (
    .vga_clk  (vga_clk),
    .reset_n  (reset_n),
    .req      (req),
    .lock     (lock),
    .addr     (addr),
    .gnt      (gnt),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .rvalid   (rvalid),
`ifdef SPRITE_ARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .rdata    (rdata)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= 5'(rom_addr % 10'd32);
  always @(posedge vga_clk) cyc++;

  assign addr = {a[3], a[2], a[1], a[0]};

  // rvalid/rdata must match exactly the entry due this cycle, else be zero.
  always @(negedge vga_clk) begin
    logic [3:0] ev;
    logic [4:0] ed;
    ev = '0;
    ed = '0;
    if (sb.size() > 0 && sb[0].c == cyc) begin
      ev = sb[0].v;
      ed = sb[0].d;
      void'(sb.pop_front());
    end
    checks++;
    if (rvalid !== ev || (ev != 0 && rdata !== ed)) begin
      errors++;
      $display("FAIL rvalid_rdata cyc=%0d got %b/%0d want %b/%0d",
               cyc, rvalid, rdata, ev, ed);
    end
  end

  task automatic sb_push(input logic [3:0] g);
    exp_t e;
    e.v = g;
    e.d = '0;
    e.c = cyc + 1;
    for (int i = 0; i < 4; i++)
      if (g[i]) e.d = 5'(a[i] % 10'd32);
    if (g != 0) sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic idle_cycle();
    req  = '0;
    lock = '0;
    @(negedge vga_clk);
    next_cycle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 4'b1111;
    lock    = 4'b0000;
    #3;
    checks++;
    if (gnt !== 4'b0000 || rvalid !== 4'b0000 || rom_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b rvalid=%b rom_addr=%0d want 0/0/0",
               gnt, rvalid, rom_addr);
    end
    next_cycle();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gnt_held got %b want 0000", gnt);
    end
    req     = '0;
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [5];
    eg   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req  = 4'b1111;
    lock = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge vga_clk);
      checks++;
      if (gnt !== eg[k]) begin
        errors++;
        $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, eg[k]);
      end
      sb_push(eg[k]);
      next_cycle();
    end
    req = '0;
    @(negedge vga_clk);
    checks++;
    if (gnt !== 4'b0000 || rom_addr !== a[0]) begin
      errors++;
      $display("FAIL rr_hold got gnt=%b rom_addr=%0d want 0000/%0d",
               gnt, rom_addr, a[0]);
    end
    next_cycle();
  endtask

  task automatic test_single();
    req  = 4'b0100;
    lock = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge vga_clk);
      checks++;
      if (gnt !== 4'b0100 || rom_addr !== 10'd37) begin
        errors++;
        $display("FAIL single_gnt[%0d] got %b/%0d want 0100/37",
                 k, gnt, rom_addr);
      end
      sb_push(4'b0100);
      next_cycle();
    end
    idle_cycle();
  endtask

  task automatic test_burst_max();
    req  = 4'b0001;
    lock = 4'b0000;
    @(negedge vga_clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL burst_setup got %b want 0001", gnt);
    end
    sb_push(4'b0001);
    next_cycle();
    req  = 4'b1111;
    lock = 4'b0010;
    for (int k = 0; k < 9; k++) begin
      logic [3:0] e;
      e = (k < 8) ? 4'b0010 : 4'b0100;
      @(negedge vga_clk);
      checks++;
      if (gnt !== e) begin
        errors++;
        $display("FAIL burst_gnt[%0d] got %b want %b", k, gnt, e);
      end
      sb_push(e);
      next_cycle();
    end
    idle_cycle();
  endtask

  task automatic test_owner_drop();
    req  = 4'b0001;
    lock = 4'b0000;
    @(negedge vga_clk);
    sb_push(4'b0001);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL drop_setup got %b want 0001", gnt);
    end
    next_cycle();
    req  = 4'b1010;
    lock = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge vga_clk);
      checks++;
      if (gnt !== 4'b0010) begin
        errors++;
        $display("FAIL drop_burst[%0d] got %b want 0010", k, gnt);
      end
      sb_push(4'b0010);
      next_cycle();
    end
    req = 4'b1000;
    @(negedge vga_clk);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL drop_no_bubble got %b want 1000", gnt);
    end
    sb_push(4'b1000);
    next_cycle();
    idle_cycle();
  endtask

  task automatic test_lock_drop();
    logic [3:0] eg [4];
    logic [3:0] lk [4];
    eg  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    lk  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      lock = lk[k];
      @(negedge vga_clk);
      checks++;
      if (gnt !== eg[k]) begin
        errors++;
        $display("FAIL lockdrop_gnt[%0d] got %b want %b", k, gnt, eg[k]);
      end
      sb_push(eg[k]);
      next_cycle();
    end
    // Lock without req must not start a burst for the idle requesters.
    req  = 4'b0100;
    lock = 4'b1011;
    for (int k = 0; k < 2; k++) begin
      @(negedge vga_clk);
      checks++;
      if (gnt !== 4'b0100) begin
        errors++;
        $display("FAIL lock_no_req[%0d] got %b want 0100", k, gnt);
      end
      sb_push(4'b0100);
      next_cycle();
    end
    req  = 4'b1001;
    lock = 4'b0110;
    @(negedge vga_clk);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL lock_no_req_rr got %b want 1000", gnt);
    end
    sb_push(4'b1000);
    next_cycle();
    idle_cycle();
  endtask

  task automatic test_reset_mid_burst();
    req  = 4'b0100;
    lock = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      @(negedge vga_clk);
      sb_push(4'b0100);
      next_cycle();
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || rvalid !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_burst got gnt=%b rvalid=%b want 0000/0000",
               gnt, rvalid);
    end
    sb.delete();
    next_cycle();
    reset_n = 1'b1;
    req     = 4'b1100;
    lock    = 4'b0000;
    @(negedge vga_clk);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL rst_first_gnt got %b want 0100", gnt);
    end
    sb_push(4'b0100);
    next_cycle();
    idle_cycle();
    idle_cycle();
  endtask

`ifdef SPRITE_ARB_STATS_EN
  task automatic test_stats();
    req  = 4'b0001;
    lock = 4'b0000;
    for (int k = 0; k < 70000; k++) begin
      @(negedge vga_clk);
      sb_push(4'b0001);
      next_cycle();
    end
    idle_cycle();
    checks++;
    if (grant_cnt[15:0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_sat got %h want ffff", grant_cnt[15:0]);
    end
  endtask
`endif

  initial begin
    a[0] = 10'd100;
    a[1] = 10'd201;
    a[2] = 10'd37;
    a[3] = 10'd1000;
    req  = '0;
    lock = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_burst_max();
    test_owner_drop();
    test_lock_drop();
    test_reset_mid_burst();
`ifdef SPRITE_ARB_STATS_EN
    test_stats();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
